risc_v_decode: RTL and testbench
================================

Name: risc_v_decode

Overview:
Instruction decode stage for the RV32I pipeline. It sits between fetch and execute, and is the only driver of the register file read ports (re1/raddr1, re2/raddr2).
- Accepts one instruction per cycle over a valid/ready handshake.
- Reads the register file combinationally and expands the immediate.
- Registers the result into the ID/EX output register.
- Stalls on read-after-write hazards using a 32-entry pending-write scoreboard that writeback clears.

Parameters:
WIDTH1, 32, data/PC/instruction width
WIDTH2, 5, register address width (1<<WIDTH2 scoreboard entries)

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
if_valid  in  1  fetch presents an instruction
if_ready  out  1  decode accepts this cycle
if_instr  in  WIDTH1  instruction word
if_pc  in  WIDTH1  instruction PC
re1, re2  out  1  register file read enables
raddr1, raddr2  out  WIDTH2  register file read addresses
rdata1, rdata2  in  WIDTH1  register file read data (combinational, write-through)
wb_valid  in  1  writeback retires a register write
wb_rd  in  WIDTH2  destination being retired
flush  in  1  squash the decode output register and drop the input this cycle
ex_valid  out  1  ID/EX register holds an instruction
ex_ready  in  1  execute accepts
ex_pc, ex_rs1_val, ex_rs2_val, ex_imm  out  WIDTH1  registered operands
ex_rd  out  WIDTH2  destination register
ex_rd_we  out  1  instruction writes rd (rd != 0)
ex_opcode  out  7  opcode[6:0]
ex_funct3  out  3  instr[14:12]
ex_funct7b5  out  1  instr[30]
ex_illegal  out  1  see Optional Feature

Behaviour:
Decode (combinational on if_instr):
- rs1 = [19:15], rs2 = [24:20], rd = [11:7].
- Format by opcode:
  - R 0110011
  - I 0010011 / 0000011 / 1100111
  - S 0100011
  - B 1100011
  - U 0110111 / 0010111
  - J 1101111
- re1 = if_valid and format in {R, I, S, B}; raddr1 = rs1 (0 when re1 is low).
- re2 = if_valid and format in {R, S, B}; raddr2 = rs2 (0 when re2 is low).
- Immediate per the RV32I spec, sign-extended from instr[31]. Zero for R.
- rd_we = format in {R, I, U, J} and rd != 0.

Hazard (per used source rs, rs != 0):
- Stall if scoreboard[rs] is set and not (wb_valid and wb_rd == rs) in the same cycle. The register file's write-through covers the same-cycle clear.
- Also stall if ex_valid, ex_rd_we and ex_rd == rs.

Handshake:
- if_ready = (!ex_valid or ex_ready) and !hazard and !flush.
- The output register loads on if_valid and if_ready, capturing rdata1/rdata2 in that same cycle. Zero added latency: ID/EX is valid the cycle after acceptance.
- If ex_valid and ex_ready with no load, ex_valid drops to 0.
- Outputs hold stable while ex_valid and !ex_ready.

Scoreboard:
- Bit ex_rd is set on the EX handshake (ex_valid and ex_ready and ex_rd_we).
- Bit wb_rd is cleared on wb_valid.
- Set and clear of the same bit in one cycle: set wins.
- Bit 0 is never set.

Flush:
- ex_valid becomes 0 next cycle; input is not accepted; scoreboard untouched.
- Flush together with ex_ready still sets the scoreboard bit for the departing instruction.

Reset (reset == 0 at a clk edge):
- ex_valid = 0, scoreboard = 0.
- All ex_* data outputs = 0.
- Reset mid-stall discards the held instruction.

Optional Feature:
Macro: RISCV_DEC_ILLEGAL_EN.
- Defined: an unknown opcode, or instr[1:0] != 2'b11, is still accepted. ex_illegal = 1, ex_rd_we = 0, re1 = re2 = 0, and no scoreboard effect.
- Undefined: ex_illegal is tied to 0, and unknown opcodes decode as R format with rd_we = 0.

Decomposition:
Shared package risc_v_pkg:
- opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR)
- format enum {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J}
- WIDTH constants

One natural sub-module: risc_v_imm_gen (combinational: instr -> format, imm).

Test Plan:
1. Reset low 2 cycles, then addi x1, x0, 5 (0x00500093) with ex_ready=1 -> next cycle ex_valid=1, ex_imm=5, ex_rd=1, ex_rd_we=1, re1=1, raddr1=0, re2=0.
2. addi x1 issued, then add x2, x1, x1 with no writeback -> if_ready=0. Then wb_valid=1, wb_rd=1 -> add accepted that same cycle and ex_rs1_val equals the wdata driven at writeback.
3. ex_ready=0 for 3 cycles with ex_valid=1 -> all ex_* outputs stable, if_ready=0; ex_ready=1 -> next instruction loads.
4. Immediate checks:
   - sw x2, -4(x3) (0xFE21AE23) -> ex_imm=0xFFFFFFFC, re2=1, ex_rd_we=0.
   - beq with imm=-8 -> ex_imm=0xFFFFFFF8.
   - lui 0x12345 -> ex_imm=0x12345000.
5. flush=1 while ex_valid=1 and ex_ready=0 -> ex_valid=0 next cycle, if_ready=0 during flush, scoreboard unchanged.
6. With RISCV_DEC_ILLEGAL_EN: instr 0x00000000 -> ex_illegal=1, ex_rd_we=0. Without the macro: ex_illegal=0.

Source files
------------

// File: rtl/risc_v_pkg.sv
// risc_v_pkg: shared RV32I decode constants, opcodes and instruction format enum
package risc_v_pkg;
  localparam int DATA_W = 32;
  localparam int REG_W = 5;
  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J} fmt_t;
endpackage

// File: rtl/risc_v_imm_gen.sv
// risc_v_imm_gen: instr -> format, known-opcode flag and sign-extended 32-bit immediate
module risc_v_imm_gen
  import risc_v_pkg::*;
(
  input  logic [31:0] instr,
  output fmt_t        fmt,
  output logic        known,
  output logic [31:0] imm
);
  logic [6:0] op;
  logic s;
  assign op = instr[6:0];
  assign s = instr[31];
  always_comb begin
    known = 1'b1;
    fmt = FMT_R;
    case (op)
      OP_R: fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR: fmt = FMT_I;
      OP_STORE: fmt = FMT_S;
      OP_BRANCH: fmt = FMT_B;
      OP_LUI, OP_AUIPC: fmt = FMT_U;
      OP_JAL: fmt = FMT_J;
      default: known = 1'b0;
    endcase
  end
  assign imm = fmt == FMT_I ? {{20{s}}, instr[31:20]} :
               fmt == FMT_S ? {{20{s}}, instr[31:25], instr[11:7]} :
               fmt == FMT_B ? {{20{s}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
               fmt == FMT_U ? {instr[31:12], 12'b0} :
               fmt == FMT_J ? {{12{s}}, instr[19:12], instr[20], instr[30:21], 1'b0} : 32'b0;
endmodule

// File: rtl/risc_v_decode.sv
// risc_v_decode: RV32I decode stage, regfile read, ID/EX register, RAW scoreboard; RISCV_DEC_ILLEGAL_EN flags illegal opcodes
module risc_v_decode
  import risc_v_pkg::*;
#(
  parameter int WIDTH1 = DATA_W,
  parameter int WIDTH2 = REG_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  output logic              if_ready,
  input  logic [WIDTH1-1:0] if_instr,
  input  logic [WIDTH1-1:0] if_pc,
  output logic              re1,
  output logic              re2,
  output logic [WIDTH2-1:0] raddr1,
  output logic [WIDTH2-1:0] raddr2,
  input  logic [WIDTH1-1:0] rdata1,
  input  logic [WIDTH1-1:0] rdata2,
  input  logic              wb_valid,
  input  logic [WIDTH2-1:0] wb_rd,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [WIDTH1-1:0] ex_pc,
  output logic [WIDTH1-1:0] ex_rs1_val,
  output logic [WIDTH1-1:0] ex_rs2_val,
  output logic [WIDTH1-1:0] ex_imm,
  output logic [WIDTH2-1:0] ex_rd,
  output logic              ex_rd_we,
  output logic [6:0]        ex_opcode,
  output logic [2:0]        ex_funct3,
  output logic              ex_funct7b5,
  output logic              ex_illegal
);
  fmt_t fmt;
  logic known, ill, use1, use2, rd_we, haz1, haz2, load;
  logic [31:0] imm;
  logic [WIDTH1-1:0] imm_ext;
  logic [WIDTH2-1:0] rs1, rs2, rd;
  logic [(1<<WIDTH2)-1:0] sb, sb_n;
  risc_v_imm_gen u_imm (.instr(if_instr[31:0]), .fmt(fmt), .known(known), .imm(imm));
  assign imm_ext = WIDTH1'($signed(imm));
  assign rs1 = if_instr[19:15];
  assign rs2 = if_instr[24:20];
  assign rd = if_instr[11:7];
`ifdef RISCV_DEC_ILLEGAL_EN
  assign ill = !known || if_instr[1:0] != 2'b11;
`else
  assign ill = 1'b0;
`endif
  assign use1 = !ill && (fmt == FMT_R || fmt == FMT_I || fmt == FMT_S || fmt == FMT_B);
  assign use2 = !ill && (fmt == FMT_R || fmt == FMT_S || fmt == FMT_B);
  assign rd_we = known && !ill && (fmt == FMT_R || fmt == FMT_I || fmt == FMT_U || fmt == FMT_J) && rd != '0;
  assign re1 = if_valid && use1;
  assign re2 = if_valid && use2;
  assign raddr1 = re1 ? rs1 : '0;
  assign raddr2 = re2 ? rs2 : '0;
  // A same-cycle writeback of rs is forwarded by the regfile write-through, so it clears the stall
  assign haz1 = use1 && rs1 != '0 &&
                ((sb[rs1] && !(wb_valid && wb_rd == rs1)) || (ex_valid && ex_rd_we && ex_rd == rs1));
  assign haz2 = use2 && rs2 != '0 &&
                ((sb[rs2] && !(wb_valid && wb_rd == rs2)) || (ex_valid && ex_rd_we && ex_rd == rs2));
  assign if_ready = (!ex_valid || ex_ready) && !haz1 && !haz2 && !flush;
  assign load = if_valid && if_ready;
  always_comb begin
    sb_n = sb;
    if (wb_valid) sb_n[wb_rd] = 1'b0;
    if (ex_valid && ex_ready && ex_rd_we) sb_n[ex_rd] = 1'b1;
    sb_n[0] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      sb <= '0;
      ex_valid <= 1'b0;
      ex_pc <= '0;
      ex_rs1_val <= '0;
      ex_rs2_val <= '0;
      ex_imm <= '0;
      ex_rd <= '0;
      ex_rd_we <= 1'b0;
      ex_opcode <= '0;
      ex_funct3 <= '0;
      ex_funct7b5 <= 1'b0;
    end else begin
      sb <= sb_n;
      if (flush) ex_valid <= 1'b0;
      else if (load) begin
        ex_valid <= 1'b1;
        ex_pc <= if_pc;
        ex_rs1_val <= rdata1;
        ex_rs2_val <= rdata2;
        ex_imm <= imm_ext;
        ex_rd <= rd;
        ex_rd_we <= rd_we;
        ex_opcode <= if_instr[6:0];
        ex_funct3 <= if_instr[14:12];
        ex_funct7b5 <= if_instr[30];
      end else if (ex_ready) ex_valid <= 1'b0;
    end
  end
`ifdef RISCV_DEC_ILLEGAL_EN
  always_ff @(posedge clk) begin
    if (!reset) ex_illegal <= 1'b0;
    else if (!flush && load) ex_illegal <= ill;
  end
`else
  assign ex_illegal = 1'b0;
`endif
endmodule

// File: tb/tb_risc_v_decode.sv
// tb_risc_v_decode: directed self-checking bench for risc_v_decode with a write-through regfile model
module tb_risc_v_decode;
  logic clk = 1'b0, reset = 1'b0;
  logic if_valid, if_ready, re1, re2, wb_valid, flush, ex_valid, ex_ready;
  logic ex_rd_we, ex_funct7b5, ex_illegal;
  logic [31:0] if_instr, if_pc, rdata1, rdata2, wb_data;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0] raddr1, raddr2, wb_rd, ex_rd;
  logic [6:0] ex_opcode;
  logic [2:0] ex_funct3;
  logic [31:0] rf [32] = '{default: 32'b0};
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  always @(posedge clk) if (wb_valid && wb_rd != 5'd0) rf[wb_rd] <= wb_data;
  assign rdata1 = raddr1 == 5'd0 ? 32'b0 : (wb_valid && wb_rd == raddr1) ? wb_data : rf[raddr1];
  assign rdata2 = raddr2 == 5'd0 ? 32'b0 : (wb_valid && wb_rd == raddr2) ? wb_data : rf[raddr2];
  risc_v_decode dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr),
    .if_pc(if_pc), .re1(re1), .re2(re2), .raddr1(raddr1), .raddr2(raddr2), .rdata1(rdata1),
    .rdata2(rdata2), .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush), .ex_valid(ex_valid),
    .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_rd_we(ex_rd_we), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5), .ex_illegal(ex_illegal)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic present(input logic [31:0] ins, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = ins;
    if_pc = pc;
    #1;
  endtask
  task automatic wb(input logic [4:0] r, input logic [31:0] d);
    wb_valid = 1'b1;
    wb_rd = r;
    wb_data = d;
    #1;
  endtask
  initial begin
    if_valid = 1'b0; if_instr = '0; if_pc = '0; wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    flush = 1'b0; ex_ready = 1'b1;
    repeat (2) tick;
    chk("rst_valid", ex_valid, 0);
    chk("rst_imm", ex_imm, 0);
    chk("rst_pc", ex_pc, 0);
    chk("rst_rd", ex_rd, 0);
    reset = 1'b1;
    present(32'h00500093, 32'h100);
    chk("addi_re1", re1, 1);
    chk("addi_raddr1", raddr1, 0);
    chk("addi_re2", re2, 0);
    chk("addi_rdy", if_ready, 1);
    tick;
    chk("addi_valid", ex_valid, 1);
    chk("addi_imm", ex_imm, 5);
    chk("addi_rd", ex_rd, 1);
    chk("addi_we", ex_rd_we, 1);
    chk("addi_pc", ex_pc, 32'h100);
    present(32'h00108133, 32'h104);
    chk("raw_ex_rdy", if_ready, 0);
    tick;
    chk("raw_drain", ex_valid, 0);
    chk("raw_sb_rdy", if_ready, 0);
    wb(5'd1, 32'h55);
    chk("raw_wb_rdy", if_ready, 1);
    tick;
    wb_valid = 1'b0; if_valid = 1'b0;
    chk("add_valid", ex_valid, 1);
    chk("add_rs1", ex_rs1_val, 32'h55);
    chk("add_rs2", ex_rs2_val, 32'h55);
    chk("add_rd", ex_rd, 2);
    ex_ready = 1'b0;
    present(32'h123452B7, 32'h108);
    chk("lui_re1", re1, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("stall_rdy", if_ready, 0);
      chk("stall_valid", ex_valid, 1);
      chk("stall_pc", ex_pc, 32'h104);
      chk("stall_rs1", ex_rs1_val, 32'h55);
      chk("stall_rd", ex_rd, 2);
    end
    ex_ready = 1'b1;
    #1;
    chk("unstall_rdy", if_ready, 1);
    tick;
    chk("lui_imm", ex_imm, 32'h12345000);
    chk("lui_rd", ex_rd, 5);
    chk("lui_op", ex_opcode, 7'h37);
    present(32'hFE21AE23, 32'h10C);
    chk("sw_re2", re2, 1);
    chk("sw_raddr2", raddr2, 2);
    chk("sw_raw_rdy", if_ready, 0);
    wb(5'd2, 32'h77);
    chk("sw_wb_rdy", if_ready, 1);
    tick;
    wb_valid = 1'b0;
    chk("sw_imm", ex_imm, 32'hFFFFFFFC);
    chk("sw_we", ex_rd_we, 0);
    chk("sw_rs2", ex_rs2_val, 32'h77);
    chk("sw_f3", ex_funct3, 2);
    chk("sw_f7b5", ex_funct7b5, 1);
    present(32'hFE000CE3, 32'h110);
    chk("beq_rdy", if_ready, 1);
    tick;
    chk("beq_imm", ex_imm, 32'hFFFFFFF8);
    chk("beq_op", ex_opcode, 7'h63);
    ex_ready = 1'b0; flush = 1'b1;
    present(32'h00100313, 32'h114);
    chk("flush_rdy", if_ready, 0);
    tick;
    flush = 1'b0;
    chk("flush_valid", ex_valid, 0);
    present(32'h000283B3, 32'h118);
    chk("flush_sb_kept", if_ready, 0);
    wb(5'd5, 32'h99);
    chk("x5_wb_rdy", if_ready, 1);
    tick;
    wb_valid = 1'b0; if_valid = 1'b0;
    chk("add7_valid", ex_valid, 1);
    chk("add7_rd", ex_rd, 7);
    chk("add7_rs1", ex_rs1_val, 32'h99);
    flush = 1'b1; ex_ready = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush_rdy_valid", ex_valid, 0);
    present(32'h00038433, 32'h11C);
    chk("flush_sb_set", if_ready, 0);
    ex_ready = 1'b0;
    present(32'h00100313, 32'h120);
    tick;
    chk("addi6_valid", ex_valid, 1);
    present(32'h00038433, 32'h124);
    tick;
    chk("hold_valid", ex_valid, 1);
    reset = 1'b0;
    tick;
    reset = 1'b1;
    chk("mid_rst_valid", ex_valid, 0);
    chk("mid_rst_pc", ex_pc, 0);
    chk("mid_rst_sb", if_ready, 1);
    ex_ready = 1'b1;
    present(32'h00000000, 32'h128);
`ifdef RISCV_DEC_ILLEGAL_EN
    chk("ill_re1", re1, 0);
`else
    chk("ill_re1", re1, 1);
`endif
    tick;
`ifdef RISCV_DEC_ILLEGAL_EN
    chk("ill_flag", ex_illegal, 1);
`else
    chk("ill_flag", ex_illegal, 0);
`endif
    chk("ill_we", ex_rd_we, 0);
    present(32'h00000080, 32'h12C);
    tick;
    if_valid = 1'b0;
    chk("ill_rd1_we", ex_rd_we, 0);
    chk("ill_rd1_valid", ex_valid, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
